// File: rtl/ola_pkg.sv
// Shared types and constants for the overlap-add synthesis stage.
// Build with OLA_SAT_EN defined to saturate sample_out instead of wrapping.
package ola_pkg;
  localparam int ACC_DEPTH = 2048;
  localparam int ACC_DEPTH_LOG2 = $clog2(ACC_DEPTH);
  localparam int ACC_W = 26;
  localparam int LEAD = 16;
  localparam int OUT_SHIFT = 8;
  localparam int SMP_W = 16;
  localparam int WIN_W = 24;
  localparam int SH_W = ACC_W - OUT_SHIFT;

  typedef enum logic [1:0] {CLEAR, IDLE, GRAIN, DRAIN} state_e;

  typedef logic [ACC_DEPTH_LOG2-1:0] addr_t;
  typedef logic signed [ACC_W-1:0]   acc_t;
  typedef logic signed [SMP_W-1:0]   sample_t;
  typedef logic signed [WIN_W-1:0]   win_t;

  function automatic sample_t to_sample(acc_t a);
`ifdef OLA_SAT_EN
    logic signed [SH_W-1:0] s;
    s = a[ACC_W-1:OUT_SHIFT];
    if (s > SH_W'(32767))
      return 16'sh7fff;
    else if (s < SH_W'(-32768))
      return 16'sh8000;
    else
      return s[SMP_W-1:0];
`else
    return a[OUT_SHIFT+SMP_W-1:OUT_SHIFT];
`endif
  endfunction
endpackage

// File: rtl/ola_acc_ram.sv
// Dual-port accumulator RAM, synchronous read, one cycle latency.
// Port B write takes priority over port A on an address collision.
module ola_acc_ram
  import ola_pkg::*;
(
  input  logic  clk,
  input  logic  a_we,
  input  addr_t a_waddr,
  input  acc_t  a_wdata,
  input  addr_t a_raddr,
  output acc_t  a_rdata,
  input  logic  b_we,
  input  addr_t b_waddr,
  input  acc_t  b_wdata,
  input  addr_t b_raddr,
  output acc_t  b_rdata
);
  acc_t mem [ACC_DEPTH];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_waddr] <= a_wdata;
    if (b_we) mem[b_waddr] <= b_wdata;
    a_rdata <= mem[a_raddr];
    b_rdata <= mem[b_raddr];
  end
endmodule

// File: rtl/overlap_add.sv
// Overlap-add of windowed grains into a circular accumulator.
// sample_out saturation selected by OLA_SAT_EN (see ola_pkg).
module overlap_add
  import ola_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             grain_start,
  input  logic [9:0]       win_size,
  input  logic [9:0]       hop,
  input  logic             grain_valid,
  input  logic [WIN_W-1:0] windowed_in,
  output logic             grain_busy,
  input  logic             sample_tick,
  output logic [SMP_W-1:0] sample_out,
  output logic             sample_valid,
  output logic             late
);
  state_e state_q, state_d;
  addr_t clr_q, clr_d, base_q, base_d;
  addr_t nbase_q, nbase_d, optr_q, optr_d;
  logic [9:0] k_q, k_d, win_q, win_d;
  logic drn_q, drn_d, late_q, late_d;
  logic busy_q, busy_d;
  logic s1_v_q, s1_v_d, s1_f_q, s1_f_d;
  addr_t s1_a_q, s1_a_d;
  win_t s1_x_q, s1_x_d;
  acc_t s1_fd_q, s1_fd_d;
  logic o1_v_q, o1_v_d, o1_c_q, o1_c_d;
  logic o1_f_q, o1_f_d;
  acc_t o1_fd_q, o1_fd_d;
  logic sv_q, sv_d;
  sample_t so_q, so_d;

  logic a_we, b_we;
  addr_t a_waddr, tgt;
  acc_t a_wdata, a_rdata, b_rdata;
  acc_t old, sum, oval;
  logic tlate, issue, collide, tick_go;

  ola_acc_ram u_ram (
    .clk     (clock),
    .a_we    (a_we),
    .a_waddr (a_waddr),
    .a_wdata (a_wdata),
    .a_raddr (tgt),
    .a_rdata (a_rdata),
    .b_we    (b_we),
    .b_waddr (optr_q),
    .b_wdata ('0),
    .b_raddr (optr_q),
    .b_rdata (b_rdata)
  );

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    base_d  = base_q;
    nbase_d = nbase_q;
    optr_d  = optr_q;
    k_d     = k_q;
    win_d   = win_q;
    drn_d   = drn_q;

    tgt   = base_q + addr_t'(k_q);
    tlate = addr_t'(tgt - optr_q) == '1;
    issue = (state_q == GRAIN) && grain_valid;

    old = s1_f_q ? s1_fd_q : a_rdata;
    sum = old + {{(ACC_W-WIN_W){s1_x_q[WIN_W-1]}}, s1_x_q};

    b_we    = o1_v_q;
    collide = s1_v_q && b_we && (s1_a_q == optr_q);
    a_we    = 1'b0;
    a_waddr = s1_a_q;
    a_wdata = sum;
    if (state_q == CLEAR) begin
      a_we    = 1'b1;
      a_waddr = clr_q;
      a_wdata = '0;
    end else if (s1_v_q && !collide) begin
      a_we = 1'b1;
    end
    late_d = late_q | collide | (issue && tlate);

    // read-before-write RAM: forward any same-cycle write
    s1_v_d  = issue && !tlate;
    s1_a_d  = tgt;
    s1_x_d  = windowed_in;
    s1_f_d  = 1'b0;
    s1_fd_d = a_wdata;
    if (b_we && optr_q == tgt) begin
      s1_f_d  = 1'b1;
      s1_fd_d = '0;
    end else if (a_we && a_waddr == tgt) begin
      s1_f_d = 1'b1;
    end

    tick_go = sample_tick && !o1_v_q;
    o1_v_d  = tick_go;
    o1_c_d  = (state_q == CLEAR);
    o1_f_d  = a_we && (a_waddr == optr_q);
    o1_fd_d = a_wdata;

    oval = o1_c_q ? '0 : (o1_f_q ? o1_fd_q : b_rdata);
    sv_d = o1_v_q;
    so_d = o1_v_q ? to_sample(oval) : so_q;
    if (o1_v_q) optr_d = optr_q + addr_t'(1);

    unique case (state_q)
      CLEAR: begin
        clr_d = clr_q + addr_t'(1);
        if (clr_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (grain_start) begin
          base_d  = nbase_q;
          nbase_d = nbase_q + addr_t'(hop);
          k_d     = '0;
          win_d   = (win_size == 10'd0) ? 10'd1 : win_size;
          state_d = GRAIN;
        end
      end
      GRAIN: begin
        if (grain_valid) begin
          k_d = k_q + 10'd1;
          if (k_d == win_q) begin
            state_d = DRAIN;
            drn_d   = 1'b0;
          end
        end
      end
      DRAIN: begin
        drn_d = 1'b1;
        if (drn_q) state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase

    busy_d = (state_d == GRAIN) || (state_d == DRAIN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      clr_q   <= '0;
      base_q  <= '0;
      nbase_q <= addr_t'(LEAD);
      optr_q  <= '0;
      k_q     <= '0;
      win_q   <= '0;
      drn_q   <= 1'b0;
      late_q  <= 1'b0;
      busy_q  <= 1'b0;
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_x_q  <= '0;
      s1_f_q  <= 1'b0;
      s1_fd_q <= '0;
      o1_v_q  <= 1'b0;
      o1_c_q  <= 1'b0;
      o1_f_q  <= 1'b0;
      o1_fd_q <= '0;
      sv_q    <= 1'b0;
      so_q    <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      base_q  <= base_d;
      nbase_q <= nbase_d;
      optr_q  <= optr_d;
      k_q     <= k_d;
      win_q   <= win_d;
      drn_q   <= drn_d;
      late_q  <= late_d;
      busy_q  <= busy_d;
      s1_v_q  <= s1_v_d;
      s1_a_q  <= s1_a_d;
      s1_x_q  <= s1_x_d;
      s1_f_q  <= s1_f_d;
      s1_fd_q <= s1_fd_d;
      o1_v_q  <= o1_v_d;
      o1_c_q  <= o1_c_d;
      o1_f_q  <= o1_f_d;
      o1_fd_q <= o1_fd_d;
      sv_q    <= sv_d;
      so_q    <= so_d;
    end
  end

  assign grain_busy   = busy_q;
  assign late         = late_q;
  assign sample_valid = sv_q;
  assign sample_out   = so_q;
endmodule

// File: tb/tb_overlap_add.sv
// Testbench for overlap_add against a slot-array reference model.
// Model honours OLA_SAT_EN the same way as the build.
module tb_overlap_add;
  import ola_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic grain_start = 1'b0;
  logic grain_valid = 1'b0;
  logic sample_tick = 1'b0;
  logic [9:0] win_size = '0;
  logic [9:0] hop = '0;
  logic [23:0] windowed_in = '0;
  logic grain_busy, sample_valid, late;
  logic [15:0] sample_out;

  overlap_add dut (
    .clock        (clock),
    .reset        (reset),
    .grain_start  (grain_start),
    .win_size     (win_size),
    .hop          (hop),
    .grain_valid  (grain_valid),
    .windowed_in  (windowed_in),
    .grain_busy   (grain_busy),
    .sample_tick  (sample_tick),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .late         (late)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  localparam longint MASK = (longint'(1) << ACC_W) - 1;
  longint m [ACC_DEPTH];
  int optr, nbase;
  logic mlate;
  int gq [$];

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mout(input longint v);
    longint s, q;
    s = (v >= (longint'(1) << (ACC_W-1))) ? v - (longint'(1) << ACC_W) : v;
    q = s >>> OUT_SHIFT;
`ifdef OLA_SAT_EN
    if (q > 32767) return 16'h7fff;
    if (q < -32768) return 16'h8000;
`endif
    return q[15:0];
  endfunction

  task automatic mreset;
    for (int i = 0; i < ACC_DEPTH; i++) m[i] = 0;
    optr = 0;
    nbase = LEAD;
    mlate = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    grain_start = 1'b0;
    grain_valid = 1'b0;
    sample_tick = 1'b0;
    step;
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_out", 32'(sample_out), 0);
    chk("rst_late", 32'(late), 0);
    chk("rst_busy", 32'(grain_busy), 0);
    reset = 1'b0;
    mreset;
  endtask

  task automatic wait_clear;
    repeat (ACC_DEPTH + 12) step;
  endtask

  task automatic do_tick;
    logic [15:0] e;
    e = mout(m[optr]);
    m[optr] = 0;
    optr = (optr + 1) % ACC_DEPTH;
    sample_tick = 1'b1;
    step;
    sample_tick = 1'b0;
    step;
    chk("tick_valid", 32'(sample_valid), 1);
    chk($sformatf("sample@%0d", (optr + ACC_DEPTH - 1) % ACC_DEPTH),
        32'(sample_out), 32'(e));
  endtask

  task automatic do_grain(input int ws, input int hp);
    int n, base, a, d, cnt;
    n = (ws == 0) ? 1 : ws;
    base = nbase;
    nbase = (nbase + hp) % ACC_DEPTH;
    win_size = 10'(ws);
    hop = 10'(hp);
    grain_start = 1'b1;
    step;
    grain_start = 1'b0;
    chk("busy_hi", 32'(grain_busy), 1);
    for (int i = 0; i < n; i++) begin
      grain_valid = 1'b1;
      windowed_in = 24'(gq[i]);
      step;
      a = (base + i) % ACC_DEPTH;
      d = (a - optr + ACC_DEPTH) % ACC_DEPTH;
      if (d >= ACC_DEPTH - 1) mlate = 1'b1;
      else m[a] = (m[a] + longint'(gq[i])) & MASK;
    end
    grain_valid = 1'b0;
    cnt = 0;
    while (grain_busy === 1'b1 && cnt < 8) begin
      step;
      cnt++;
    end
    chk("busy_drop", 32'(grain_busy), 0);
    chk("late", 32'(late), 32'(mlate));
  endtask

  initial begin
    int ws, hp, r;

    // reset clear: outputs zero, grain_start ignored in CLEAR
    do_reset;
    win_size = 10'd4;
    hop = 10'd4;
    for (int i = 0; i < 2100; i++) begin
      grain_start = (i < 50);
      do_tick;
      chk("clr_busy", 32'(grain_busy), 0);
    end
    grain_start = 1'b0;

    // single grain
    do_reset;
    wait_clear;
    gq = '{256, 512, 768, 1024};
    do_grain(4, 4);
    repeat (24) do_tick;

    // two overlapping grains
    do_reset;
    wait_clear;
    gq = '{256, 256, 256, 256, 256, 256, 256, 256};
    do_grain(8, 4);
    do_grain(8, 4);
    repeat (32) do_tick;

    // positive and negative extremes
    do_reset;
    wait_clear;
    gq = '{8388607};
    do_grain(1, 0);
    do_grain(1, 0);
    do_grain(1, 0);
    do_grain(1, 1);
    gq = '{-8388608};
    repeat (4) do_grain(1, 0);
    repeat (20) do_tick;

    // late: base one slot behind the reader
    do_reset;
    wait_clear;
    repeat (LEAD + 1) do_tick;
    gq = '{256, 512, 768};
    do_grain(3, 0);
    chk("late_set", 32'(late), 1);
    repeat (6) do_tick;

    // reset mid-grain at k=3
    win_size = 10'd8;
    hop = 10'd0;
    grain_start = 1'b1;
    step;
    grain_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      grain_valid = 1'b1;
      windowed_in = 24'd4096;
      step;
    end
    chk("mid_busy", 32'(grain_busy), 1);
    do_reset;
    wait_clear;
    gq = '{512};
    do_grain(0, 4);
    repeat (20) do_tick;

    // randomized grains interleaved with reader progress
    do_reset;
    wait_clear;
    for (int g = 0; g < 10; g++) begin
      repeat ($urandom_range(0, 6)) do_tick;
      ws = int'($urandom_range(1, 24));
      hp = int'($urandom_range(0, 12));
      gq.delete();
      for (int i = 0; i < ws; i++) begin
        r = int'($urandom_range(0, 16777215));
        if (r >= 8388608) r -= 16777216;
        if ($urandom_range(0, 3) != 0) r = r / 64;
        gq.push_back(r);
      end
      do_grain(ws, hp);
    end
    repeat (120) do_tick;
    chk("rand_late", 32'(late), 32'(mlate));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
